// File: rtl/prog_seq_mem_pkg.sv
// Shared types and default widths for the program-memory sequencer.
package prog_seq_pkg;

  localparam int DEF_INSTR_W = 3;
  localparam int DEF_DATA_W  = 13;
  localparam int DEF_ADDR_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE
  } state_e;

endpackage

// File: rtl/prog_seq_mem_if.sv
// Opcode issue / result return channel between the sequencer and the control unit.
interface prog_seq_mem_if #(
  parameter int INSTR_W = 3,
  parameter int DATA_W  = 13
);
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [DATA_W-1:0]  res_data;
  logic               res_valid;

  modport master (
    output instr, instr_valid,
    input  instr_ready, res_data, res_valid
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, res_data, res_valid
  );
endinterface

// File: rtl/prog_seq_mem_sram_1p.sv
// Single-port synchronous SRAM: write has priority, read data is registered and held.
module sram_1p #(
  parameter int W      = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re && !we) rdata_d = mem[addr];
  end

  // Read register is cleared so the readback port is 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/prog_seq_mem.sv
// Program-memory sequencer: loads opcodes, replays them over valid/ready, captures results.
// Define PROG_SEQ_LOOP_EN to make the program repeat until stop instead of ending in DONE.
module prog_seq_mem
  import prog_seq_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               stop,
  prog_seq_mem_if.master     cu,
  input  logic               dump_rd,
  input  logic [ADDR_W-1:0]  dump_addr,
  output logic [DATA_W-1:0]  dump_data,
  output logic               dump_valid,
  output logic [ADDR_W:0]    prog_len,
  output logic [ADDR_W:0]    res_cnt,
  output logic               busy,
  output logic               done,
  output logic               load_err,
  output logic               res_err
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_d, state_q;
  logic [ADDR_W:0]   pc_d, pc_q, pc_inc;
  logic [ADDR_W:0]   prog_len_d, prog_len_q;
  logic [ADDR_W:0]   res_cnt_d, res_cnt_q;
  logic              load_err_d, load_err_q;
  logic              res_err_d, res_err_q;
  logic              dump_valid_d, dump_valid_q;
  logic              im_we, im_re, dm_we;
  logic [ADDR_W-1:0] im_addr, dm_addr;
  logic [INSTR_W-1:0] im_rdata;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    prog_len_d   = prog_len_q;
    res_cnt_d    = res_cnt_q;
    load_err_d   = load_err_q;
    res_err_d    = res_err_q;
    im_we        = 1'b0;
    im_re        = 1'b0;
    im_addr      = prog_len_q[ADDR_W-1:0];
    dm_we        = 1'b0;
    pc_inc       = pc_q + 1'b1;

    if (cu.res_valid && state_q != S_IDLE) begin
      if (res_cnt_q == DEPTH) begin
        res_err_d = 1'b1;
      end else begin
        dm_we     = 1'b1;
        res_cnt_d = res_cnt_q + 1'b1;
      end
    end

    // A load racing start, arriving while running, or into a full program is lost.
    if (load) begin
      if (state_q != S_IDLE || start || prog_len_q == DEPTH) begin
        load_err_d = 1'b1;
      end else begin
        im_we      = 1'b1;
        prog_len_d = prog_len_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (clr) begin
          prog_len_d = '0;
          pc_d       = '0;
          res_cnt_d  = '0;
          load_err_d = 1'b0;
          res_err_d  = 1'b0;
          im_we      = 1'b0;
          dm_we      = 1'b0;
        end else if (start) begin
          pc_d      = '0;
          res_cnt_d = '0;
          state_d   = (prog_len_q == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        im_re   = 1'b1;
        im_addr = pc_q[ADDR_W-1:0];
        state_d = stop ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (cu.instr_ready) begin
          if (pc_inc == prog_len_q) begin
`ifdef PROG_SEQ_LOOP_EN
            pc_d    = '0;
            state_d = S_FETCH;
`else
            pc_d    = pc_inc;
            state_d = S_DONE;
`endif
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    dm_addr      = dm_we ? res_cnt_q[ADDR_W-1:0] : dump_addr;
    dump_valid_d = dump_rd && !dm_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      prog_len_q   <= '0;
      res_cnt_q    <= '0;
      load_err_q   <= 1'b0;
      res_err_q    <= 1'b0;
      dump_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      prog_len_q   <= prog_len_d;
      res_cnt_q    <= res_cnt_d;
      load_err_q   <= load_err_d;
      res_err_q    <= res_err_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  sram_1p #(.W(INSTR_W), .ADDR_W(ADDR_W)) u_imem (
    .clk   (clk),
    .rst   (rst),
    .we    (im_we),
    .re    (im_re),
    .addr  (im_addr),
    .wdata (load_data),
    .rdata (im_rdata)
  );

  sram_1p #(.W(DATA_W), .ADDR_W(ADDR_W)) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .we    (dm_we),
    .re    (dump_rd),
    .addr  (dm_addr),
    .wdata (cu.res_data),
    .rdata (dump_data)
  );

  assign cu.instr       = im_rdata;
  assign cu.instr_valid = (state_q == S_ISSUE);
  assign busy           = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign done           = (state_q == S_DONE);
  assign prog_len       = prog_len_q;
  assign res_cnt        = res_cnt_q;
  assign load_err       = load_err_q;
  assign res_err        = res_err_q;
  assign dump_valid     = dump_valid_q;
endmodule
